mc_cond_controller: RTL and testbench

// Multicycle ARMv4 control unit. A state machine sequences each instruction through

---
 rtl/mc_cond_controller_if.sv | 30 +++
 rtl/mc_cond_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_mc_cond_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mc_cond_controller_if.sv
// Bus between the multicycle ARMv4 controller and the shared datapath.
// The controller drives the strobes, mux selects and flags; the datapath supplies IR and ALU flags.
interface mc_cond_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic [3:0]  Flags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;

    modport master (
        input  Instr, ALUFlags,
        output Flags, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
        output ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc
    );

    modport slave (
        output Instr, ALUFlags,
        input  Flags, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
        input  ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc
    );
endinterface

// File: rtl/mc_cond_controller.sv
// Multicycle ARMv4 control unit with NZCV flags and conditional squash.
// Optional retire/squash counters are enabled by defining PERF_CNT_EN.
module mc_cond_controller #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter int         CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    mc_cond_controller_if.master bus
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   retired_cnt,
    output logic [CNT_W-1:0]   squash_cnt
`endif
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       rd_pc;
    logic       cond_ex;
    logic [1:0] alu_dec;
    logic       n_f, z_f, c_f, v_f;
    logic       unused_rn;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign rd        = bus.Instr[3:0];
    assign rd_pc     = (rd == 4'hF);
    assign unused_rn = ^bus.Instr[7:4];
    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f & !z_f;
            4'b1001: cond_ex = !c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        alu_dec = 2'b00;
        case (funct[4:1])
            4'b0100: alu_dec = 2'b00;
            4'b0010: alu_dec = 2'b01;
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            default: alu_dec = 2'b00;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            flags_q <= RESET_FLAGS;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Next state; the condition is judged only here, against pre-instruction flags
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (!cond_ex) begin
                    state_d = FETCH;
                end else begin
                    unique case (op)
                        2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEMADR:   state_d = funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWR:    state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Logic ops leave C and V untouched
    always_comb begin
        flags_d = flags_q;
        if ((state_q == EXECUTER || state_q == EXECUTEI) && funct[0]) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
            if (!alu_dec[1]) begin
                flags_d[1:0] = bus.ALUFlags[1:0];
            end
        end
    end

    // Outputs
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = 2'b00;
        unique case (state_q)
            FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = 1'b1;
            end
            DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            MEMADR: bus.ALUSrcB = 2'b01;
            MEMRD:  bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.PCWrite   = rd_pc;
                bus.RegWrite  = !rd_pc;
            end
            MEMWR: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            EXECUTER: bus.ALUControl = alu_dec;
            EXECUTEI: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_dec;
            end
            ALUWB: begin
                bus.PCWrite  = rd_pc;
                bus.RegWrite = !rd_pc;
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            bus.PCWrite  = 1'b0;
            bus.MemWrite = 1'b0;
            bus.RegWrite = 1'b0;
            bus.IRWrite  = 1'b0;
        end
    end

    assign bus.Flags  = flags_q;
    assign bus.ImmSrc = op;
    assign bus.RegSrc = {op == 2'b01, op == 2'b10};

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] squash_q, squash_d;

    always_comb begin
        retired_d = retired_q;
        squash_d  = squash_q;
        if (state_d == FETCH) begin
            if (state_q == DECODE) begin
                squash_d = squash_q + CNT_W'(1);
            end else if (state_q != FETCH) begin
                retired_d = retired_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            squash_q  <= '0;
        end else begin
            retired_q <= retired_d;
            squash_q  <= squash_d;
        end
    end

    assign retired_cnt = retired_q;
    assign squash_cnt  = squash_q;
`endif

endmodule

// File: tb/tb_mc_cond_controller.sv
// Scoreboard bench for mc_cond_controller: driver queues per-cycle expected
// control vectors, a negedge monitor pops and compares them.
module tb_mc_cond_controller;

    logic clk;
    logic reset;

    mc_cond_controller_if bus ();

`ifdef PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] squash_cnt;
`endif

    mc_cond_controller dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.master)
`ifdef PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .squash_cnt  (squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [19:0] exp;
        logic [19:0] mask;
    } sb_t;

    sb_t sb[$];
    int  n_vec;
    int  n_bad;
    logic [3:0] exp_flags;
    int  exp_ret;
    int  exp_sq;

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl}
    function automatic logic [11:0] ctl(bit pcw, bit memw, bit regw, bit irw,
                                        bit adr, bit srca, bit [1:0] srcb,
                                        bit [1:0] res, bit [1:0] aluc);
        return {pcw, memw, regw, irw, adr, srca, srcb, res, aluc};
    endfunction

    function automatic logic [19:0] mk(logic [3:0] cnd, logic [1:0] o,
                                       logic [5:0] f, logic [3:0] d);
        return {cnd, o, f, 4'h0, d};
    endfunction

    task automatic cyc(string nm, logic [11:0] c, logic [3:0] af,
                       bit rst = 1'b0, logic [19:0] msk = 20'hFFFFF);
        logic [1:0] o;
        sb_t e;
        o = bus.Instr[15:14];
        reset = rst;
        bus.ALUFlags = af;
        e.name = nm;
        e.exp  = {c, o, o == 2'b01, o == 2'b10, exp_flags};
        e.mask = msk;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fd(string nm, logic [19:0] ins);
        bus.Instr = ins;
        cyc({nm, ".fetch"}, ctl(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00), 4'h0);
        cyc({nm, ".decode"}, ctl(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00), 4'h0);
    endtask

    task automatic squash(string nm, logic [19:0] ins);
        fd(nm, ins);
        exp_sq++;
    endtask

    task automatic alu(string nm, logic [19:0] ins, bit immi, logic [1:0] aluc,
                       logic [3:0] af, logic [3:0] new_flags);
        bit pc;
        pc = (ins[3:0] == 4'hF);
        fd(nm, ins);
        cyc({nm, ".exec"}, ctl(0, 0, 0, 0, 0, 0, immi ? 2'b01 : 2'b00, 2'b00, aluc), af);
        exp_flags = new_flags;
        cyc({nm, ".aluwb"}, ctl(pc, 0, !pc, 0, 0, 0, 2'b00, 2'b00, 2'b00), 4'h0);
        exp_ret++;
    endtask

    task automatic ldr(string nm, logic [19:0] ins);
        bit pc;
        pc = (ins[3:0] == 4'hF);
        fd(nm, ins);
        cyc({nm, ".memadr"}, ctl(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00), 4'h0);
        cyc({nm, ".memrd"}, ctl(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00), 4'h0);
        cyc({nm, ".memwb"}, ctl(pc, 0, !pc, 0, 0, 0, 2'b00, 2'b01, 2'b00), 4'h0);
        exp_ret++;
    endtask

    task automatic str(string nm, logic [19:0] ins, bit rst_wr);
        fd(nm, ins);
        cyc({nm, ".memadr"}, ctl(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00), 4'h0);
        if (rst_wr) begin
            cyc({nm, ".memwr_rst"}, ctl(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00), 4'h0, 1'b1);
            exp_flags = 4'b0000;
            exp_ret = 0;
            exp_sq = 0;
        end else begin
            cyc({nm, ".memwr"}, ctl(0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00), 4'h0);
            exp_ret++;
        end
    endtask

    task automatic br(string nm, logic [19:0] ins);
        fd(nm, ins);
        cyc({nm, ".branch"}, ctl(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00), 4'h0);
        exp_ret++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            logic [19:0] got;
            e = sb.pop_front();
            got = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite,
                   bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                   bus.ALUControl, bus.ImmSrc, bus.RegSrc, bus.Flags};
            n_vec++;
            if (((got ^ e.exp) & e.mask) != 20'h0) begin
                n_bad++;
                $display("FAIL %s: got %05h expected %05h (mask %05h)",
                         e.name, got, e.exp, e.mask);
            end
        end
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        exp_flags = 4'b0000;
        exp_ret = 0;
        exp_sq = 0;
        reset = 1'b1;
        bus.Instr = 20'h0;
        bus.ALUFlags = 4'h0;
        @(posedge clk);
        #1;
        cyc("reset", 12'h000, 4'h0, 1'b1, 20'hF000F);

        squash("beq_z0", mk(4'b0000, 2'b10, 6'b100000, 4'h0));
        squash("undef_op11", mk(4'b1110, 2'b11, 6'b000000, 4'h0));
        alu("adds", mk(4'b1110, 2'b00, 6'b001001, 4'h1), 0, 2'b00, 4'b0110, 4'b0110);
        alu("adds_cv", mk(4'b1110, 2'b00, 6'b001001, 4'h2), 0, 2'b00, 4'b0011, 4'b0011);
        alu("ands", mk(4'b1110, 2'b00, 6'b000001, 4'h3), 0, 2'b10, 4'b1100, 4'b1111);
        alu("subi_pc", mk(4'b1110, 2'b00, 6'b100100, 4'hF), 1, 2'b01, 4'b1010, 4'b1111);
        squash("bgt_false", mk(4'b1100, 2'b10, 6'b100000, 4'h0));
        br("bge_taken", mk(4'b1010, 2'b10, 6'b100000, 4'h0));
        alu("orrs", mk(4'b1110, 2'b00, 6'b011001, 4'h4), 0, 2'b11, 4'b0000, 4'b0011);
        alu("subs_ne", mk(4'b0001, 2'b00, 6'b000101, 4'h5), 0, 2'b01, 4'b0100, 4'b0100);
        squash("never", mk(4'b1111, 2'b00, 6'b001001, 4'h6));
        ldr("ldr_pc", mk(4'b1110, 2'b01, 6'b011001, 4'hF));
        ldr("ldr_r2", mk(4'b1110, 2'b01, 6'b011001, 4'h2));
        str("str", mk(4'b1110, 2'b01, 6'b011000, 4'h3), 1'b0);
        str("str_rst", mk(4'b1110, 2'b01, 6'b011000, 4'h3), 1'b1);
        alu("add_after_rst", mk(4'b1110, 2'b00, 6'b001000, 4'h7), 0, 2'b00, 4'b1111, 4'b0000);

        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
`ifdef PERF_CNT_EN
        n_vec++;
        if (retired_cnt != 32'(exp_ret)) begin
            n_bad++;
            $display("FAIL retired_cnt: got %0d expected %0d", retired_cnt, exp_ret);
        end
        n_vec++;
        if (squash_cnt != 32'(exp_sq)) begin
            n_bad++;
            $display("FAIL squash_cnt: got %0d expected %0d", squash_cnt, exp_sq);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
